pipeline_hazard_ctrl: RTL

Sequencing controller for the 5-stage in-order core (IF, ID, EX, MEM, WB).
- Tracks destination registers of in-flight instructions in a shift-register scoreboard.
- Stalls IF/ID and injects an ID/EX bubble on read-after-write hazards.
- Flushes younger instructions when a branch resolves taken in EX/MEM.
- Keeps saturating stall and flush event counters for the power/performance debug path.

---
 rtl/pipeline_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Sequencing controller for a 5-stage in-order core (IF, ID, EX, MEM, WB).
//   * A shift-register scoreboard records the destination register of every
//     in-flight instruction in EX, MEM and WB.
//   * A read-after-write hazard on the instruction in IF/ID holds the PC and
//     IF/ID (stall_if_o) and loads a bubble into ID/EX (bubble_ex_o).
//   * A taken branch resolved in EX/MEM raises flush_o for FLUSH_CYCLES
//     cycles, killing the younger IF/ID and ID/EX contents.
//   * Saturating stall and flush event counters feed the debug path.
//
// Optional feature macro: RF_WB_BYPASS_EN
//   Defined   : the register file is write-before-read, so the WB entry is
//               left out of the hazard compare (max stall SB_DEPTH-1 cycles).
//   Undefined : every scoreboard entry is compared (max stall SB_DEPTH cycles).
//
// Reset is synchronous and active-high; while rst is high all three control
// outputs are held low.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned SB_DEPTH       = 3,   // EX, MEM, WB
    parameter int unsigned FLUSH_CYCLES   = 2,   // 1..7
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,

    // Instruction currently in IF/ID
    input  logic                      id_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
    input  logic                      id_uses_rs1_i,
    input  logic                      id_uses_rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_i,
    input  logic                      id_reg_w_i,

    // Branch resolution from EX/MEM
    input  logic                      br_taken_i,

    // Pipeline control
    output logic                      stall_if_o,
    output logic                      bubble_ex_o,
    output logic                      flush_o,

    // Debug event counters
    output logic [CNT_WIDTH-1:0]      stall_count_o,
    output logic [CNT_WIDTH-1:0]      flush_count_o
);

    // -------------------------------------------------------------------------
    // Local parameters
    // -------------------------------------------------------------------------
    // Three bits cover the full 1..7 flush length range.
    localparam int unsigned FC_W = 3;

`ifdef RF_WB_BYPASS_EN
    // WB writes the register file before ID reads it, so WB never hazards.
    localparam int unsigned CMP_DEPTH = SB_DEPTH - 1;
`else
    localparam int unsigned CMP_DEPTH = SB_DEPTH;
`endif

    localparam logic [FC_W-1:0]      FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [FC_W-1:0]      FC_ONE     = FC_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    // -------------------------------------------------------------------------
    // Types and state
    // -------------------------------------------------------------------------
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e                                   state_q, state_d;
    logic [FC_W-1:0]                          flush_cnt_q, flush_cnt_d;

    // Scoreboard: index 0 is EX, index SB_DEPTH-1 is WB.
    logic [SB_DEPTH-1:0]                      sb_valid_q, sb_valid_d;
    logic [SB_DEPTH-1:0][REG_ADDR_WIDTH-1:0]  sb_rd_q, sb_rd_d;

    logic [CNT_WIDTH-1:0]                     stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]                     flush_evt_q, flush_evt_d;

    // -------------------------------------------------------------------------
    // Combinational control signals
    // -------------------------------------------------------------------------
    logic                                     rs1_live;
    logic                                     rs2_live;
    logic [SB_DEPTH-1:0]                      entry_match;
    logic                                     hazard;
    logic                                     flush;
    logic                                     flush_event;
    logic                                     stall;
    logic                                     issue;

    // A source only matters when it is actually read and is not x0.
    assign rs1_live = id_uses_rs1_i && (id_rs1_i != '0);
    assign rs2_live = id_uses_rs2_i && (id_rs2_i != '0);

    // Per-entry RAW compare; entries beyond CMP_DEPTH never match.
    for (genvar k = 0; k < SB_DEPTH; k++) begin : g_cmp
        if (k < CMP_DEPTH) begin : g_live
            assign entry_match[k] = sb_valid_q[k] &&
                                    ((rs1_live && (sb_rd_q[k] == id_rs1_i)) ||
                                     (rs2_live && (sb_rd_q[k] == id_rs2_i)));
        end else begin : g_bypassed
            assign entry_match[k] = 1'b0;
        end
    end

    assign hazard = id_valid_i && (|entry_match);

    // Flush outranks the hazard: the stalled instruction is being killed anyway.
    assign stall = hazard && !flush && !rst;

    // Only real, register-writing, non-x0 instructions that actually leave ID
    // occupy a scoreboard slot.
    assign issue = id_valid_i && id_reg_w_i && (id_rd_i != '0) && !stall && !flush;

    assign stall_if_o  = stall;
    assign bubble_ex_o = stall;
    assign flush_o     = flush;

    // -------------------------------------------------------------------------
    // Flush FSM: next state, flush length counter and flush output
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        flush       = 1'b0;
        flush_event = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (br_taken_i) begin
                    flush       = 1'b1;
                    flush_event = 1'b1;
                    // A one-cycle flush is fully covered by this RUN cycle.
                    if (FLUSH_CYCLES > 1) begin
                        flush_cnt_d = FLUSH_LOAD;
                        state_d     = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // br_taken_i is ignored here: that branch is already killed.
                flush       = 1'b1;
                flush_cnt_d = flush_cnt_q - FC_ONE;
                if (flush_cnt_q <= FC_ONE) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (rst) begin
            flush       = 1'b0;
            flush_event = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard shift: new entry enters EX, the WB entry drops out
    // -------------------------------------------------------------------------
    always_comb begin
        sb_valid_d = {sb_valid_q[SB_DEPTH-2:0], issue};
        sb_rd_d    = {sb_rd_q[SB_DEPTH-2:0], (issue ? id_rd_i : '0)};
    end

    // -------------------------------------------------------------------------
    // Saturating event counters
    // -------------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_evt_d = flush_evt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush_event && (flush_evt_q != CNT_MAX)) begin
            flush_evt_d = flush_evt_q + CNT_ONE;
        end
    end

    assign stall_count_o = stall_cnt_q;
    assign flush_count_o = flush_evt_q;

    // -------------------------------------------------------------------------
    // State registers with synchronous reset
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            // NOTE: the scoreboard is reset as a whole; it is control state,
            // and a stale valid bit after reset would raise a false stall.
            sb_valid_q  <= '0;
            sb_rd_q     <= '0;
            stall_cnt_q <= '0;
            flush_evt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            sb_valid_q  <= sb_valid_d;
            sb_rd_q     <= sb_rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_evt_q <= flush_evt_d;
        end
    end

endmodule
